reg_file_scoreboard: RTL and testbench
======================================

Name: reg_file_scoreboard

Overview:
- Parametrised integer register file for the pipeline; the successor to the fixed 64x31 array.
- Adds a per-register in-flight write scoreboard: counts issued-but-not-written-back results per destination.
- Drives read-hazard flags and an issue stall to decode.
- Sits between decode (read/issue) and the MEM3/WB stage (writeback).

Parameters:
- XLEN, 64, data width of each register.
- NREG, 32, number of architectural registers; index 0 is hardwired zero.
- AW, 5, register index width, clog2(NREG).
- CNTW, 2, width of each scoreboard counter; max in-flight writes per register = 2^CNTW-1.
- SP_IDX, 2, index of register given a non-zero reset value.
- SP_RESET, 64'h10000, reset value of register SP_IDX.

Ports:
- CLK  in  1  clock, all state on rising edge.
- RST  in  1  asynchronous, active-high reset.
- RS1_SEL  in  AW  read port 1 index.
- RS2_SEL  in  AW  read port 2 index.
- RS1_DATAOUT  out  XLEN  read port 1 data.
- RS2_DATAOUT  out  XLEN  read port 2 data.
- RS1_PENDING  out  1  RS1_SEL has a non-zero scoreboard count.
- RS2_PENDING  out  1  RS2_SEL has a non-zero scoreboard count.
- ISSUE_VALID  in  1  decode issues an instruction writing ISSUE_RD.
- ISSUE_RD  in  AW  destination of the issuing instruction.
- ISSUE_STALL  out  1  ISSUE_RD counter saturated; the issue is not accepted.
- RD_WB_VALID_MEM3_WB  in  1  writeback valid.
- RD_WB_MEM3_WB  in  AW  writeback destination.
- DATA_IN  in  XLEN  writeback data.
- FLUSH  in  1  pipeline flush; clears all scoreboard counters.

Behaviour:
- Reset, asserted asynchronously at any time including mid-operation:
  - all registers = 0, except register SP_IDX = SP_RESET;
  - all counters = 0;
  - outputs follow from this state: DATAOUT = 0 (SP_IDX reads SP_RESET), PENDING = 0, ISSUE_STALL = 0.
- Reads: combinational, zero latency. Index 0 returns 0 with PENDING = 0. Index >= NREG returns 0, PENDING = 0.
- Write: on rising CLK when RD_WB_VALID_MEM3_WB=1 and RD_WB_MEM3_WB != 0, the register takes DATA_IN. A read of that register shows the new value from the next cycle, unless the optional feature is enabled.
- ISSUE_STALL = ISSUE_VALID && ISSUE_RD != 0 && cnt[ISSUE_RD] == 2^CNTW-1, evaluated before any same-cycle writeback decrement.
- Issue accepted = ISSUE_VALID && ISSUE_RD != 0 && !ISSUE_STALL.
- Counter update per register r, per clock:
  - accepted issue to r only: +1;
  - valid writeback to r only with cnt > 0: -1;
  - writeback to r with cnt == 0: data still written, counter stays 0, no error;
  - issue and writeback to the same r in one cycle: counter unchanged;
  - stalled issue plus writeback to r: -1.
- FLUSH=1: all counters set to 0 on that edge and override same-cycle issue/writeback counter effects. Same-cycle writeback data is still written.
- Issue or writeback to index 0: no state change.

Optional Feature:
- Macro: REG_FILE_BYPASS_EN.
- Defined:
  - write-through forwarding: if RD_WB_VALID_MEM3_WB && RD_WB_MEM3_WB == RSx_SEL != 0, RSx_DATAOUT = DATA_IN in the same cycle;
  - RSx_PENDING = (cnt > 1) in that case, since the arriving writeback retires one count.
- Undefined:
  - no forwarding; read data and PENDING reflect registered state only.

Test Plan:
- Reset: assert RST asynchronously between edges -> read x2 = 64'h10000, x5 = 0, all PENDING = 0, ISSUE_STALL = 0, with no clock edge required.
- Issue/writeback: issue x7, next cycle RS1_SEL=7 -> RS1_PENDING=1. Writeback x7 = 64'hDEAD_BEEF -> next cycle RS1_DATAOUT = 64'hDEAD_BEEF, RS1_PENDING = 0.
- Saturation (CNTW=2): issue x9 three times -> 4th ISSUE_VALID to x9 gives ISSUE_STALL=1 and count stays 3. Same cycle as a writeback to x9 -> ISSUE_STALL still 1, count becomes 2.
- Simultaneous issue and writeback to x4 with count 1 -> count stays 1, data written, RS2_PENDING=1.
- x0: issue x0 and writeback x0 = 64'h1234 -> RS1_SEL=0 reads 0, PENDING 0, ISSUE_STALL 0.
- FLUSH with x3 count 2 and a same-cycle writeback x3 = 64'h55 -> next cycle count 0, x3 = 64'h55. With REG_FILE_BYPASS_EN, a writeback x6 = 64'hAA reads 64'hAA in the same cycle.

Source files
------------

// File: rtl/reg_file_scoreboard.sv
// Integer register file with a per-register in-flight write scoreboard, read-hazard flags and issue stall.
// Define REG_FILE_BYPASS_EN to forward same-cycle writeback data onto the read ports.
module reg_file_scoreboard #(
  parameter int              XLEN     = 64,
  parameter int              NREG     = 32,
  parameter int              AW       = 5,
  parameter int              CNTW     = 2,
  parameter int              SP_IDX   = 2,
  parameter logic [XLEN-1:0] SP_RESET = 64'h10000
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic [AW-1:0]   RS1_SEL,
  input  logic [AW-1:0]   RS2_SEL,
  output logic [XLEN-1:0] RS1_DATAOUT,
  output logic [XLEN-1:0] RS2_DATAOUT,
  output logic            RS1_PENDING,
  output logic            RS2_PENDING,
  input  logic            ISSUE_VALID,
  input  logic [AW-1:0]   ISSUE_RD,
  output logic            ISSUE_STALL,
  input  logic            RD_WB_VALID_MEM3_WB,
  input  logic [AW-1:0]   RD_WB_MEM3_WB,
  input  logic [XLEN-1:0] DATA_IN,
  input  logic            FLUSH
);

  localparam logic [CNTW-1:0] CNT_MAX = '1;

  logic [XLEN-1:0] regs [NREG];
  logic [CNTW-1:0] cnt  [NREG];
  logic            issue_hit;
  logic            issue_acc;
  logic            wb_hit;

  // Index 0 is hardwired zero and anything past NREG does not exist.
  function automatic logic idx_ok(input logic [AW-1:0] idx);
    return (idx != '0) && (int'(idx) < NREG);
  endfunction

  assign issue_hit   = ISSUE_VALID && idx_ok(ISSUE_RD);
  assign ISSUE_STALL = issue_hit && (cnt[ISSUE_RD] == CNT_MAX);
  assign issue_acc   = issue_hit && !ISSUE_STALL;
  assign wb_hit      = RD_WB_VALID_MEM3_WB && idx_ok(RD_WB_MEM3_WB);

  always_comb begin
    RS1_DATAOUT = '0;
    RS1_PENDING = 1'b0;
    if (idx_ok(RS1_SEL)) begin
      RS1_DATAOUT = regs[RS1_SEL];
      RS1_PENDING = (cnt[RS1_SEL] != '0);
`ifdef REG_FILE_BYPASS_EN
      if (wb_hit && (RD_WB_MEM3_WB == RS1_SEL)) begin
        RS1_DATAOUT = DATA_IN;
        RS1_PENDING = (cnt[RS1_SEL] > CNTW'(1));
      end
`endif
    end
  end

  always_comb begin
    RS2_DATAOUT = '0;
    RS2_PENDING = 1'b0;
    if (idx_ok(RS2_SEL)) begin
      RS2_DATAOUT = regs[RS2_SEL];
      RS2_PENDING = (cnt[RS2_SEL] != '0);
`ifdef REG_FILE_BYPASS_EN
      if (wb_hit && (RD_WB_MEM3_WB == RS2_SEL)) begin
        RS2_DATAOUT = DATA_IN;
        RS2_PENDING = (cnt[RS2_SEL] > CNTW'(1));
      end
`endif
    end
  end

  // An issue and a writeback to the same register cancel; a writeback to an idle register leaves it at 0.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < NREG; i++) begin
        regs[i] <= (i == SP_IDX) ? SP_RESET : '0;
        cnt[i]  <= '0;
      end
    end else begin
      if (wb_hit) regs[RD_WB_MEM3_WB] <= DATA_IN;
      for (int r = 1; r < NREG; r++) begin
        if (FLUSH) begin
          cnt[r] <= '0;
        end else if (issue_acc && (ISSUE_RD == AW'(r))) begin
          if (!(wb_hit && (RD_WB_MEM3_WB == AW'(r)))) cnt[r] <= cnt[r] + 1'b1;
        end else if (wb_hit && (RD_WB_MEM3_WB == AW'(r)) && (cnt[r] != '0)) begin
          cnt[r] <= cnt[r] - 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_reg_file_scoreboard.sv
// Scoreboard bench for reg_file_scoreboard: expected read/stall outputs are queued as stimulus is driven.
module tb_reg_file_scoreboard;
  localparam int XLEN = 64;
  localparam int NREG = 32;
  localparam int AW   = 5;
  localparam int CMAX = 3;

  logic            CLK = 1'b0;
  logic            RST;
  logic [AW-1:0]   RS1_SEL, RS2_SEL, ISSUE_RD, RD_WB_MEM3_WB;
  logic [XLEN-1:0] RS1_DATAOUT, RS2_DATAOUT, DATA_IN;
  logic            RS1_PENDING, RS2_PENDING, ISSUE_VALID, ISSUE_STALL;
  logic            RD_WB_VALID_MEM3_WB, FLUSH;

  always #5 CLK = ~CLK;

  reg_file_scoreboard #(
    .XLEN(XLEN), .NREG(NREG), .AW(AW), .CNTW(2), .SP_IDX(2), .SP_RESET(64'h10000)
  ) dut (
    .CLK(CLK), .RST(RST),
    .RS1_SEL(RS1_SEL), .RS2_SEL(RS2_SEL),
    .RS1_DATAOUT(RS1_DATAOUT), .RS2_DATAOUT(RS2_DATAOUT),
    .RS1_PENDING(RS1_PENDING), .RS2_PENDING(RS2_PENDING),
    .ISSUE_VALID(ISSUE_VALID), .ISSUE_RD(ISSUE_RD), .ISSUE_STALL(ISSUE_STALL),
    .RD_WB_VALID_MEM3_WB(RD_WB_VALID_MEM3_WB), .RD_WB_MEM3_WB(RD_WB_MEM3_WB),
    .DATA_IN(DATA_IN), .FLUSH(FLUSH)
  );

  typedef struct {
    string           tag;
    logic [XLEN-1:0] d1, d2;
    logic            p1, p2, stall;
  } exp_t;

  exp_t            exp_q[$];
  int              n_checks = 0;
  int              n_pass   = 0;
  logic [XLEN-1:0] m_regs[NREG];
  int              m_cnt[NREG];

  task automatic checkOutput(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("[TB] FAIL %s: got %h, expected %h", tag, obs, exp);
  endtask

  task automatic modelReset();
    for (int i = 0; i < NREG; i++) begin
      m_regs[i] = '0;
      m_cnt[i]  = 0;
    end
    m_regs[2] = 64'h10000;
  endtask

  function automatic void readModel(input logic [AW-1:0] sel, output logic [XLEN-1:0] d, output logic p);
    d = '0;
    p = 1'b0;
    if (sel != 0) begin
      d = m_regs[sel];
      p = (m_cnt[sel] != 0);
`ifdef REG_FILE_BYPASS_EN
      if (RD_WB_VALID_MEM3_WB && RD_WB_MEM3_WB == sel) begin
        d = DATA_IN;
        p = (m_cnt[sel] > 1);
      end
`endif
    end
  endfunction

  function automatic exp_t predict(input string tag);
    exp_t e;
    e.tag   = tag;
    e.stall = ISSUE_VALID && (ISSUE_RD != 0) && (m_cnt[ISSUE_RD] == CMAX);
    readModel(RS1_SEL, e.d1, e.p1);
    readModel(RS2_SEL, e.d2, e.p2);
    return e;
  endfunction

  // Mirrors the clock-edge effect of the inputs currently applied.
  task automatic modelEdge();
    bit stall, acc, wb;
    stall = ISSUE_VALID && (ISSUE_RD != 0) && (m_cnt[ISSUE_RD] == CMAX);
    acc   = ISSUE_VALID && (ISSUE_RD != 0) && !stall;
    wb    = RD_WB_VALID_MEM3_WB && (RD_WB_MEM3_WB != 0);
    if (wb) m_regs[RD_WB_MEM3_WB] = DATA_IN;
    if (FLUSH) begin
      for (int i = 0; i < NREG; i++) m_cnt[i] = 0;
    end else if (!(acc && wb && ISSUE_RD == RD_WB_MEM3_WB)) begin
      if (acc) m_cnt[ISSUE_RD]++;
      if (wb && m_cnt[RD_WB_MEM3_WB] > 0) m_cnt[RD_WB_MEM3_WB]--;
    end
  endtask

  task automatic compareOutputs();
    exp_t e;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checkOutput({e.tag, ".rs1_data"}, RS1_DATAOUT, e.d1);
      checkOutput({e.tag, ".rs2_data"}, RS2_DATAOUT, e.d2);
      checkOutput({e.tag, ".rs1_pend"}, {63'b0, RS1_PENDING}, {63'b0, e.p1});
      checkOutput({e.tag, ".rs2_pend"}, {63'b0, RS2_PENDING}, {63'b0, e.p2});
      checkOutput({e.tag, ".stall"},    {63'b0, ISSUE_STALL}, {63'b0, e.stall});
    end
  endtask

  task automatic applyStimulus(input string tag, input logic [AW-1:0] rs1, input logic [AW-1:0] rs2,
                               input logic iv, input logic [AW-1:0] ird,
                               input logic wv, input logic [AW-1:0] wrd, input logic [XLEN-1:0] wdata,
                               input logic fl);
    @(negedge CLK);
    RS1_SEL = rs1; RS2_SEL = rs2;
    ISSUE_VALID = iv; ISSUE_RD = ird;
    RD_WB_VALID_MEM3_WB = wv; RD_WB_MEM3_WB = wrd; DATA_IN = wdata;
    FLUSH = fl;
    exp_q.push_back(predict(tag));
    #2;
    compareOutputs();
    @(posedge CLK);
    modelEdge();
  endtask

  initial begin
    RST = 1'b1;
    RS1_SEL = '0; RS2_SEL = '0; ISSUE_VALID = 1'b0; ISSUE_RD = '0;
    RD_WB_VALID_MEM3_WB = 1'b0; RD_WB_MEM3_WB = '0; DATA_IN = '0; FLUSH = 1'b0;
    modelReset();
    #12 RST = 1'b0;

    // Dirty x5 so that the mid-cycle reset has something to clear.
    applyStimulus("dirty_a", 5, 2, 1, 5, 1, 5, 64'h77, 0);
    applyStimulus("dirty_b", 5, 2, 1, 5, 0, 0, 64'h0, 0);
    applyStimulus("dirty_c", 5, 2, 1, 5, 0, 0, 64'h0, 0);

    @(negedge CLK);
    ISSUE_VALID = 1'b0; RS1_SEL = 2; RS2_SEL = 5;
    #2 RST = 1'b1;
    #1;
    modelReset();
    exp_q.push_back(predict("async_reset"));
    compareOutputs();
    @(negedge CLK);
    RST = 1'b0;

    applyStimulus("iss7",     7, 0, 1, 7, 0, 0, 64'h0, 0);
    applyStimulus("pend7",    7, 0, 0, 0, 0, 0, 64'h0, 0);
    applyStimulus("wb7",      7, 0, 0, 0, 1, 7, 64'hDEAD_BEEF, 0);
    applyStimulus("read7",    7, 0, 0, 0, 0, 0, 64'h0, 0);

    for (int i = 0; i < 3; i++) applyStimulus("iss9", 0, 9, 1, 9, 0, 0, 64'h0, 0);
    applyStimulus("sat9",     0, 9, 1, 9, 0, 0, 64'h0, 0);
    applyStimulus("sat9_wb",  0, 9, 1, 9, 1, 9, 64'hBB, 0);
    applyStimulus("refill9",  0, 9, 1, 9, 0, 0, 64'h0, 0);
    applyStimulus("resat9",   0, 9, 1, 9, 0, 0, 64'h0, 0);

    applyStimulus("iss4",     0, 4, 1, 4, 0, 0, 64'h0, 0);
    applyStimulus("iss_wb4",  0, 4, 1, 4, 1, 4, 64'h44, 0);
    applyStimulus("read4",    0, 4, 0, 0, 0, 0, 64'h0, 0);

    applyStimulus("x0_ops",   0, 0, 1, 0, 1, 0, 64'h1234, 0);
    applyStimulus("x0_read",  0, 0, 0, 0, 0, 0, 64'h0, 0);

    applyStimulus("iss3a",    3, 0, 1, 3, 0, 0, 64'h0, 0);
    applyStimulus("iss3b",    3, 0, 1, 3, 0, 0, 64'h0, 0);
    applyStimulus("flush3",   3, 9, 1, 3, 1, 3, 64'h55, 1);
    applyStimulus("read3",    3, 9, 0, 0, 0, 0, 64'h0, 0);

    applyStimulus("wb6",      6, 2, 0, 0, 1, 6, 64'hAA, 0);
    applyStimulus("read6",    6, 2, 0, 0, 0, 0, 64'h0, 0);

    for (int i = 0; i < 300; i++) begin
      applyStimulus("rand",
                    AW'($urandom_range(0, 10)), AW'($urandom_range(0, 10)),
                    1'($urandom_range(0, 1)), AW'($urandom_range(0, 6)),
                    1'($urandom_range(0, 1)), AW'($urandom_range(0, 6)),
                    {$urandom, $urandom}, ($urandom_range(0, 19) == 0));
    end

    $display("[TB] %0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
